// File: rtl/universal_register.sv
// universal_register: width-generic datapath register with a mode-selected
// operation on every enabled clock (hold, load, shift, rotate, inc, dec).
// q and carry are registered; zero is a direct decode of q.
module universal_register #(
    parameter int          WIDTH     = 8,
    parameter logic [31:0] RESET_VAL = 32'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             carry,
    output logic             zero
);

    // Operation encodings on the mode input.
    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_INC  = 3'b110;
    localparam logic [2:0] MODE_DEC  = 3'b111;

    // Reset value truncated to the register width.
    localparam logic [WIDTH-1:0] RESET_Q = RESET_VAL[WIDTH-1:0];

    // One in the low bit of the WIDTH+1 arithmetic intermediate.
    localparam logic [WIDTH:0] ONE_EXT = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_r;
    logic             carry_r;
    logic [WIDTH-1:0] q_next_s;
    logic             carry_next_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;

    // Shift helpers: the bit entering the vacated end is supplied by the caller,
    // so the same helpers serve both serial shifts and rotates.
    function automatic logic [WIDTH-1:0] shift_left(input logic [WIDTH-1:0] v,
                                                     input logic            fill);
        shift_left = {v[WIDTH-2:0], fill};
    endfunction

    function automatic logic [WIDTH-1:0] shift_right(input logic [WIDTH-1:0] v,
                                                      input logic            fill);
        shift_right = {fill, v[WIDTH-1:1]};
    endfunction

    // Increment and decrement in a WIDTH+1 intermediate; the top bit is carry/borrow.
    always_comb begin
        sum_s  = {1'b0, q_r} + ONE_EXT;
        diff_s = {1'b0, q_r} - ONE_EXT;
    end

    // Next-state selection: hold by default, otherwise apply the selected operation.
    always_comb begin
        q_next_s     = q_r;
        carry_next_s = carry_r;
        if (en) begin
            case (mode)
                MODE_HOLD: begin
                    q_next_s     = q_r;
                    carry_next_s = carry_r;
                end
                MODE_LOAD: begin
                    q_next_s     = d;
                    carry_next_s = 1'b0;
                end
                MODE_SHL: begin
                    q_next_s     = shift_left(q_r, sin);
                    carry_next_s = q_r[WIDTH-1];
                end
                MODE_SHR: begin
                    q_next_s     = shift_right(q_r, sin);
                    carry_next_s = q_r[0];
                end
                MODE_ROL: begin
                    q_next_s     = shift_left(q_r, q_r[WIDTH-1]);
                    carry_next_s = q_r[WIDTH-1];
                end
                MODE_ROR: begin
                    q_next_s     = shift_right(q_r, q_r[0]);
                    carry_next_s = q_r[0];
                end
                MODE_INC: begin
                    q_next_s     = sum_s[WIDTH-1:0];
                    carry_next_s = sum_s[WIDTH];
                end
                MODE_DEC: begin
                    q_next_s     = diff_s[WIDTH-1:0];
                    carry_next_s = diff_s[WIDTH];
                end
                default: begin
                    q_next_s     = q_r;
                    carry_next_s = carry_r;
                end
            endcase
        end else begin
            q_next_s     = q_r;
            carry_next_s = carry_r;
        end
    end

    // State register; synchronous reset wins over enable and mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r     <= RESET_Q;
            carry_r <= 1'b0;
        end else begin
            q_r     <= q_next_s;
            carry_r <= carry_next_s;
        end
    end

    assign q     = q_r;
    assign carry = carry_r;
    assign zero  = (q_r == {WIDTH{1'b0}});

endmodule

// File: tb/tb_universal_register.sv
// Scoreboard bench for universal_register: an 8-bit instance (RESET_VAL=0) and
// a 4-bit instance (RESET_VAL=9). The stimulus process pushes hand-computed
// expectations; a separate monitor pops and compares one entry per clock edge.
module tb_universal_register;

    logic       clk;
    logic       rst_a, en_a, sin_a, carry_a, zero_a;
    logic [2:0] mode_a;
    logic [7:0] d_a, q_a;
    logic       rst_b, en_b, sin_b, carry_b, zero_b;
    logic [2:0] mode_b;
    logic [3:0] d_b, q_b;

    typedef struct {
        bit         sel;    // 0: 8-bit instance, 1: 4-bit instance
        logic [7:0] q;
        logic       c;
        logic       z;
        string      name;
    } exp_t;

    exp_t sb[$];
    bit   stim_done;
    int   total;
    int   bad;

    localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, SHL = 3'b010, SHR = 3'b011;
    localparam logic [2:0] ROL  = 3'b100, ROR  = 3'b101, INC = 3'b110, DEC = 3'b111;

    universal_register #(.WIDTH(8), .RESET_VAL(32'd0)) dut_a (
        .clk(clk), .rst(rst_a), .en(en_a), .mode(mode_a), .d(d_a), .sin(sin_a),
        .q(q_a), .carry(carry_a), .zero(zero_a)
    );

    universal_register #(.WIDTH(4), .RESET_VAL(32'd9)) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .mode(mode_b), .d(d_b), .sin(sin_b),
        .q(q_b), .carry(carry_b), .zero(zero_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus on the selected instance and queue its expected result.
    task automatic step(input bit sel, input logic r, input logic e, input logic [2:0] m,
                        input logic [7:0] dd, input logic s,
                        input logic [7:0] eq, input logic ec, input logic ez,
                        input string nm);
        exp_t x;
        @(negedge clk);
        rst_a = 1'b0; en_a = 1'b0; mode_a = HOLD; d_a = 8'h00; sin_a = 1'b0;
        rst_b = 1'b0; en_b = 1'b0; mode_b = HOLD; d_b = 4'h0;  sin_b = 1'b0;
        if (!sel) begin
            rst_a = r; en_a = e; mode_a = m; d_a = dd; sin_a = s;
        end else begin
            rst_b = r; en_b = e; mode_b = m; d_b = dd[3:0]; sin_b = s;
        end
        x.sel = sel; x.q = eq; x.c = ec; x.z = ez; x.name = nm;
        sb.push_back(x);
        @(posedge clk);
    endtask

    // Stimulus: directed vectors with hand-computed expectations.
    initial begin
        stim_done = 1'b0;
        rst_a = 1'b0; en_a = 1'b0; mode_a = HOLD; d_a = 8'h00; sin_a = 1'b0;
        rst_b = 1'b0; en_b = 1'b0; mode_b = HOLD; d_b = 4'h0;  sin_b = 1'b0;
        @(posedge clk);
        //         sel rst en  mode  d      sin   q      c     z
        step(1'b0, 1'b1, 1'b0, HOLD, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, "reset_a");
        step(1'b0, 1'b0, 1'b1, LOAD, 8'hA5, 1'b0, 8'hA5, 1'b0, 1'b0, "load_a5");
        step(1'b0, 1'b0, 1'b0, LOAD, 8'h3C, 1'b0, 8'hA5, 1'b0, 1'b0, "en0_hold1");
        step(1'b0, 1'b0, 1'b0, LOAD, 8'h3C, 1'b0, 8'hA5, 1'b0, 1'b0, "en0_hold2");
        step(1'b0, 1'b0, 1'b1, LOAD, 8'h81, 1'b0, 8'h81, 1'b0, 1'b0, "load_81");
        step(1'b0, 1'b0, 1'b1, SHL,  8'h00, 1'b0, 8'h02, 1'b1, 1'b0, "shl_sin0");
        step(1'b0, 1'b0, 1'b1, SHR,  8'h00, 1'b1, 8'h81, 1'b0, 1'b0, "shr_sin1");
        step(1'b0, 1'b0, 1'b1, SHR,  8'h00, 1'b0, 8'h40, 1'b1, 1'b0, "shr_sin0");
        step(1'b0, 1'b0, 1'b1, LOAD, 8'h7F, 1'b0, 8'h7F, 1'b0, 1'b0, "load_7f");
        step(1'b0, 1'b0, 1'b1, SHL,  8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, "shl_sin1");
        step(1'b0, 1'b0, 1'b1, LOAD, 8'h81, 1'b0, 8'h81, 1'b0, 1'b0, "load_81b");
        step(1'b0, 1'b0, 1'b1, ROL,  8'h00, 1'b0, 8'h03, 1'b1, 1'b0, "rol");
        step(1'b0, 1'b0, 1'b1, ROR,  8'h00, 1'b0, 8'h81, 1'b1, 1'b0, "ror1");
        step(1'b0, 1'b0, 1'b1, ROR,  8'h00, 1'b0, 8'hC0, 1'b1, 1'b0, "ror2");
        step(1'b0, 1'b0, 1'b1, HOLD, 8'h12, 1'b1, 8'hC0, 1'b1, 1'b0, "mode_hold");
        step(1'b0, 1'b0, 1'b0, INC,  8'h00, 1'b0, 8'hC0, 1'b1, 1'b0, "en0_inc");
        step(1'b0, 1'b0, 1'b1, LOAD, 8'hFE, 1'b0, 8'hFE, 1'b0, 1'b0, "load_fe");
        step(1'b0, 1'b0, 1'b1, INC,  8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, "inc_fe");
        step(1'b0, 1'b0, 1'b1, INC,  8'h00, 1'b0, 8'h00, 1'b1, 1'b1, "inc_wrap");
        step(1'b0, 1'b0, 1'b1, DEC,  8'h00, 1'b0, 8'hFF, 1'b1, 1'b0, "dec_wrap");
        step(1'b0, 1'b0, 1'b1, DEC,  8'h00, 1'b0, 8'hFE, 1'b0, 1'b0, "dec_ff");
        step(1'b0, 1'b0, 1'b1, LOAD, 8'h55, 1'b0, 8'h55, 1'b0, 1'b0, "load_55");
        step(1'b0, 1'b1, 1'b1, INC,  8'h00, 1'b0, 8'h00, 1'b0, 1'b1, "rst_over_inc");
        step(1'b0, 1'b0, 1'b1, INC,  8'h00, 1'b0, 8'h01, 1'b0, 1'b0, "inc_after_rst");
        step(1'b0, 1'b0, 1'b1, DEC,  8'h00, 1'b0, 8'h00, 1'b0, 1'b1, "dec_to_zero");
        step(1'b0, 1'b0, 1'b1, LOAD, 8'h80, 1'b0, 8'h80, 1'b0, 1'b0, "load_80");
        step(1'b0, 1'b0, 1'b1, SHL,  8'h00, 1'b0, 8'h00, 1'b1, 1'b1, "shl_out1");
        step(1'b0, 1'b1, 1'b1, SHL,  8'h00, 1'b1, 8'h00, 1'b0, 1'b1, "rst_clr_carry");
        // 4-bit instance, RESET_VAL = 9
        step(1'b1, 1'b1, 1'b0, HOLD, 8'h00, 1'b0, 8'h09, 1'b0, 1'b0, "reset_b");
        step(1'b1, 1'b0, 1'b1, SHL,  8'h00, 1'b1, 8'h03, 1'b1, 1'b0, "b_shl_sin1");
        step(1'b1, 1'b0, 1'b1, LOAD, 8'h0F, 1'b0, 8'h0F, 1'b0, 1'b0, "b_load_f");
        step(1'b1, 1'b0, 1'b1, INC,  8'h00, 1'b0, 8'h00, 1'b1, 1'b1, "b_inc_wrap");
        step(1'b1, 1'b0, 1'b1, DEC,  8'h00, 1'b0, 8'h0F, 1'b1, 1'b0, "b_dec_wrap");
        step(1'b1, 1'b0, 1'b1, SHR,  8'h00, 1'b0, 8'h07, 1'b1, 1'b0, "b_shr_sin0");
        step(1'b1, 1'b0, 1'b1, ROR,  8'h00, 1'b0, 8'h0B, 1'b1, 1'b0, "b_ror");
        @(negedge clk);
        en_b = 1'b0;
        stim_done = 1'b1;
    end

    // Monitor: after each rising edge pop one expectation and compare q, carry, zero.
    initial begin
        exp_t       x;
        logic [7:0] aq;
        logic       ac, az;
        int         cycles;
        total  = 0;
        bad    = 0;
        cycles = 0;
        while (!(stim_done && sb.size() == 0) && cycles < 500) begin
            @(posedge clk);
            #1;
            cycles++;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                if (!x.sel) begin
                    aq = q_a; ac = carry_a; az = zero_a;
                end else begin
                    aq = {4'h0, q_b}; ac = carry_b; az = zero_b;
                end
                total++;
                if (aq !== x.q) begin
                    bad++;
                    $display("FAIL %s q: got %h want %h", x.name, aq, x.q);
                end
                total++;
                if (ac !== x.c) begin
                    bad++;
                    $display("FAIL %s carry: got %b want %b", x.name, ac, x.c);
                end
                total++;
                if (az !== x.z) begin
                    bad++;
                    $display("FAIL %s zero: got %b want %b", x.name, az, x.z);
                end
            end
        end
        total++;
        if (!(stim_done && sb.size() == 0)) begin
            bad++;
            $display("FAIL timeout: pending=%0d stim_done=%0d want pending=0 stim_done=1",
                     sb.size(), stim_done);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
